alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execute stage: one request in flight, result 1 cycle after accept (LHI: WORD_SIZE/2+1), held until out_ready.
// Back-to-back accept from DONE when out_ready=1; in_ready low while shifting. Define ALU_OVF_EN to add the ovf output.
module alu_exec_unit #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           aluOp,
  input  logic [5:0]           instFuncCode,
  input  logic [WORD_SIZE-1:0] read_out1,
  input  logic [WORD_SIZE-1:0] read_out2,
  input  logic [WORD_SIZE-1:0] sign_extended_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic [2:0]           funcCode,
  output logic                 skip_write_reg,
`ifdef ALU_OVF_EN
  output logic                 ovf,
`endif
  output logic                 busy
);

  localparam logic [3:0] ALU_OP = 4'd15;
  localparam logic [3:0] ADI_OP = 4'd4;
  localparam logic [3:0] ORI_OP = 4'd5;
  localparam logic [3:0] LHI_OP = 4'd6;
  localparam logic [3:0] LWD_OP = 4'd7;
  localparam logic [3:0] SWD_OP = 4'd8;
  localparam logic [3:0] JAL_OP = 4'd10;

  localparam logic [5:0] INST_FUNC_ADD = 6'd0;
  localparam logic [5:0] INST_FUNC_SUB = 6'd1;
  localparam logic [5:0] INST_FUNC_AND = 6'd2;
  localparam logic [5:0] INST_FUNC_ORR = 6'd3;
  localparam logic [5:0] INST_FUNC_NOT = 6'd4;
  localparam logic [5:0] INST_FUNC_TCP = 6'd5;
  localparam logic [5:0] INST_FUNC_SHL = 6'd6;
  localparam logic [5:0] INST_FUNC_SHR = 6'd7;
  localparam logic [5:0] INST_FUNC_JRL = 6'd26;

  localparam logic [2:0] FUNC_ADD = 3'd0;
  localparam logic [2:0] FUNC_SUB = 3'd1;
  localparam logic [2:0] FUNC_AND = 3'd2;
  localparam logic [2:0] FUNC_ORR = 3'd3;
  localparam logic [2:0] FUNC_NOT = 3'd4;
  localparam logic [2:0] FUNC_TCP = 3'd5;
  localparam logic [2:0] FUNC_SHL = 3'd6;
  localparam logic [2:0] FUNC_SHR = 3'd7;

  localparam int                   MSB      = WORD_SIZE - 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WORD_SIZE / 2);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ZERO = '0;
  localparam logic [WORD_SIZE-1:0] W_ZERO   = '0;
  localparam logic [WORD_SIZE-1:0] W_ONE    = WORD_SIZE'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               r_state, w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WORD_SIZE-1:0] r_result;
  logic [2:0]           r_func;
  logic                 r_skip;

  logic                 w_accept;
  logic [2:0]           w_func;
  logic [WORD_SIZE-1:0] w_a, w_b, w_alu;
  logic                 w_skip, w_is_lhi;

  assign in_ready       = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept       = in_valid && in_ready;
  assign out_valid      = (r_state == DONE);
  assign busy           = (r_state == SHIFT);
  assign result         = r_result;
  assign funcCode       = r_func;
  assign skip_write_reg = r_skip;

  always_comb begin
    w_func   = FUNC_ADD;
    w_a      = read_out1;
    w_b      = read_out2;
    w_skip   = 1'b0;
    w_is_lhi = 1'b0;
    case (aluOp)
      ALU_OP: begin
        case (instFuncCode)
          INST_FUNC_ADD: w_func = FUNC_ADD;
          INST_FUNC_SUB: w_func = FUNC_SUB;
          INST_FUNC_AND: w_func = FUNC_AND;
          INST_FUNC_ORR: w_func = FUNC_ORR;
          INST_FUNC_NOT: w_func = FUNC_NOT;
          INST_FUNC_TCP: w_func = FUNC_TCP;
          INST_FUNC_SHL: w_func = FUNC_SHL;
          INST_FUNC_SHR: w_func = FUNC_SHR;
          INST_FUNC_JRL: w_b    = W_ZERO;  // jump-and-link-register forwards the target
          default:       w_skip = 1'b1;
        endcase
      end
      ADI_OP, LWD_OP, SWD_OP, JAL_OP: w_b = sign_extended_imm;
      ORI_OP: begin
        w_func = FUNC_ORR;
        w_b    = sign_extended_imm;
      end
      LHI_OP: begin
        w_func   = FUNC_SHL;
        w_a      = sign_extended_imm;
        w_is_lhi = 1'b1;
      end
      default: w_skip = 1'b1;
    endcase
  end

  always_comb begin
    w_alu = w_a + w_b;
    case (w_func)
      FUNC_SUB: w_alu = w_a - w_b;
      FUNC_AND: w_alu = w_a & w_b;
      FUNC_ORR: w_alu = w_a | w_b;
      FUNC_NOT: w_alu = ~w_a;
      FUNC_TCP: w_alu = ~w_a + W_ONE;
      FUNC_SHL: w_alu = {w_a[MSB-1:0], 1'b0};
      FUNC_SHR: w_alu = {w_a[MSB], w_a[MSB:1]};
      default:  w_alu = w_a + w_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)                           w_next_state = w_is_lhi ? SHIFT : DONE;
        else if ((r_state == DONE) && out_ready) w_next_state = IDLE;
      end
      SHIFT:   if (r_cnt == CNT_ONE) w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // LHI loads the raw immediate and shifts it one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= CNT_ZERO;
      r_result <= W_ZERO;
      r_func   <= FUNC_ADD;
      r_skip   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= w_is_lhi ? CNT_LOAD : CNT_ZERO;
      r_result <= w_is_lhi ? w_a : w_alu;
      r_func   <= w_func;
      r_skip   <= w_skip;
    end else if (r_state == SHIFT) begin
      r_cnt    <= r_cnt - CNT_ONE;
      r_result <= {r_result[MSB-1:0], 1'b0};
    end
  end

`ifdef ALU_OVF_EN
  logic w_ovf, r_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (w_func == FUNC_ADD)
      w_ovf = (w_a[MSB] == w_b[MSB]) && (w_alu[MSB] != w_a[MSB]);
    else if (w_func == FUNC_SUB)
      w_ovf = (w_a[MSB] != w_b[MSB]) && (w_alu[MSB] != w_a[MSB]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_ovf <= 1'b0;
    else if (w_accept) r_ovf <= w_ovf;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WORD_SIZE=16): directed scenarios plus randomized requests against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam logic [3:0] OP_ALU = 4'd15, OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7, OP_SWD = 4'd8, OP_JAL = 4'd10, OP_BAD = 4'd2;
  localparam logic [5:0] FN_ADD = 6'd0, FN_SUB = 6'd1, FN_TCP = 6'd5, FN_SHR = 6'd7;
  localparam logic [5:0] FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_NOT, K_TCP, K_SHL, K_SHR, K_LHI} kind_e;

  logic        clk, reset_n, in_valid, in_ready, out_valid, out_ready, skip_write_reg, busy;
  logic [3:0]  aluOp;
  logic [5:0]  instFuncCode;
  logic [15:0] read_out1, read_out2, sign_extended_imm, result;
  logic [2:0]  funcCode;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WORD_SIZE(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .instFuncCode(instFuncCode), .read_out1(read_out1),
    .read_out2(read_out2), .sign_extended_imm(sign_extended_imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .funcCode(funcCode), .skip_write_reg(skip_write_reg),
`ifdef ALU_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic folded back into 0..65535.
  function automatic void model(input logic [3:0] op, input logic [5:0] fn,
                                input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                                output logic [15:0] res, output logic [2:0] fc,
                                output logic sk, output logic ov);
    kind_e k;
    int x, y, sx, sy, r;
    k = K_ADD; x = int'(a); y = int'(b); sk = 1'b0; ov = 1'b0;
    case (op)
      OP_ALU: begin
        case (fn)
          6'd0: k = K_ADD;
          6'd1: k = K_SUB;
          6'd2: k = K_AND;
          6'd3: k = K_OR;
          6'd4: k = K_NOT;
          6'd5: k = K_TCP;
          6'd6: k = K_SHL;
          6'd7: k = K_SHR;
          FN_JRL: y = 0;
          default: sk = 1'b1;
        endcase
      end
      OP_ADI, OP_LWD, OP_SWD, OP_JAL: y = int'(imm);
      OP_ORI: begin k = K_OR; y = int'(imm); end
      OP_LHI: begin k = K_LHI; x = int'(imm); end
      default: sk = 1'b1;
    endcase
    sx = (x >= 32768) ? x - 65536 : x;
    sy = (y >= 32768) ? y - 65536 : y;
    case (k)
      K_ADD: begin r = sx + sy; ov = (r > 32767) || (r < -32768); end
      K_SUB: begin r = sx - sy; ov = (r > 32767) || (r < -32768); end
      K_AND: r = x & y;
      K_OR:  r = x | y;
      K_NOT: r = 65535 - x;
      K_TCP: r = -sx;
      K_SHL: r = x * 2;
      K_SHR: r = (sx - (sx & 1)) / 2;
      default: r = x * 256;
    endcase
    r = ((r % 65536) + 65536) % 65536;
    res = r[15:0];
    case (k)
      K_ADD: fc = 3'd0;
      K_SUB: fc = 3'd1;
      K_AND: fc = 3'd2;
      K_OR:  fc = 3'd3;
      K_NOT: fc = 3'd4;
      K_TCP: fc = 3'd5;
      K_SHR: fc = 3'd7;
      default: fc = 3'd6;
    endcase
  endfunction

  task automatic run_txn(input string tag, input logic [3:0] op, input logic [5:0] fn,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                         input int stall, input logic use_want, input logic [15:0] want);
    logic [15:0] e_res;
    logic [2:0]  e_fc;
    logic        e_sk, e_ov;
    int          lat;
    model(op, fn, a, b, imm, e_res, e_fc, e_sk, e_ov);
    if (use_want) e_res = want;
    aluOp = op; instFuncCode = fn; read_out1 = a; read_out2 = b; sign_extended_imm = imm;
    in_valid = 1'b1; out_ready = (stall == 0);
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), (op == OP_LHI) ? 32'd9 : 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(e_res));
    chk({tag, "_func"}, 32'(funcCode), 32'(e_fc));
    chk({tag, "_skip"}, 32'(skip_write_reg), 32'(e_sk));
`ifdef ALU_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ov));
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(result), 32'(e_res));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  localparam logic [3:0] OPS [12] = '{OP_ALU, OP_ALU, OP_ALU, OP_ALU, OP_ADI, OP_ORI,
                                      OP_LHI, OP_LWD, OP_SWD, OP_JAL, OP_BAD, 4'd0};
  localparam logic [5:0] FNS [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                      FN_JRL, FN_WWD, FN_HLT, 6'd45};

  initial begin
    int n_busy, cyc, n_vld;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; aluOp = '0; instFuncCode = '0;
    read_out1 = '0; read_out2 = '0; sign_extended_imm = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_func", 32'(funcCode), 32'd0);
    chk("rst_skip", 32'(skip_write_reg), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    run_txn("add_ovf", OP_ALU, FN_ADD, 16'h7FFF, 16'h0001, 16'h0, 0, 1'b1, 16'h8000);

    // LHI with a competing request held on the inputs while the shift runs
    aluOp = OP_LHI; sign_extended_imm = 16'h00AB; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    aluOp = OP_ALU; instFuncCode = FN_ADD; read_out1 = 16'h1111; read_out2 = 16'h2222;
    n_busy = 0; cyc = 1;
    while (!out_valid && cyc < 30) begin
      if (busy) n_busy++;
      chk("lhi_in_ready_busy", 32'(in_ready), 32'd0);
      tick();
      cyc++;
    end
    chk("lhi_busy_cycles", 32'(n_busy), 32'd8);
    chk("lhi_latency", 32'(cyc), 32'd9);
    chk("lhi_result", 32'(result), 32'hAB00);
    chk("lhi_func", 32'(funcCode), 32'd6);
    chk("lhi_busy_done", 32'(busy), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("lhi_drain", 32'(out_valid), 32'd0);

    run_txn("shr", OP_ALU, FN_SHR, 16'h8004, 16'h0, 16'h0, 0, 1'b1, 16'hC002);
    run_txn("tcp", OP_ALU, FN_TCP, 16'h0001, 16'h0, 16'h0, 0, 1'b1, 16'hFFFF);
    run_txn("sub", OP_ALU, FN_SUB, 16'h8000, 16'h0001, 16'h0, 2, 1'b1, 16'h7FFF);
    run_txn("jrl", OP_ALU, FN_JRL, 16'h4321, 16'h1234, 16'h0, 0, 1'b1, 16'h4321);
    run_txn("wwd", OP_ALU, FN_WWD, 16'h0003, 16'h0004, 16'h0, 0, 1'b0, 16'h0);
    run_txn("bad_op", OP_BAD, FN_ADD, 16'h0010, 16'h0020, 16'h0, 0, 1'b0, 16'h0);

    // ADI held under backpressure, then ORI accepted in the release cycle
    aluOp = OP_ADI; read_out1 = 16'h1234; sign_extended_imm = 16'h0010; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    aluOp = OP_ORI; read_out1 = 16'h0F00; sign_extended_imm = 16'h00F0;
    for (int i = 0; i < 5; i++) begin
      chk("adi_hold_valid", 32'(out_valid), 32'd1);
      chk("adi_hold_result", 32'(result), 32'h1244);
      chk("adi_hold_func", 32'(funcCode), 32'd0);
      chk("adi_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_result", 32'(result), 32'h0FF0);
    chk("b2b_func", 32'(funcCode), 32'd3);
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset during LHI shifting
    aluOp = OP_LHI; sign_extended_imm = 16'h00CD; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_vld = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) n_vld++;
    end
    chk("abort_no_result", 32'(n_vld), 32'd0);

    for (int t = 0; t < 60; t++) begin
      logic [3:0]  op;
      logic [5:0]  fn;
      op = OPS[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 11)];
      run_txn("rnd", op, fn, 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), 1'b0, 16'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
